// File: rtl/csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder: operation encoding,
// segment-count helper and default segment width.
package csel_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEFAULT_SEG = 8;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return (seg == 0) ? 0 : width / seg;
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: sums a+b for both possible carry-ins so a later
// stage only has to pick the right pair once the real carry is known.
module csel_segment
  import csel_adder_pkg::*;
#(
  parameter int unsigned SEG = DEFAULT_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  output logic [SEG-1:0] sum0,
  output logic [SEG-1:0] sum1,
  output logic           cout0,
  output logic           cout1
);

  always_comb begin
    {cout0, sum0} = {1'b0, a} + {1'b0, b};
    {cout1, sum1} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor; each stage resolves one segment's
// carry so the critical path is a single SEG-bit adder. Global-stall flow control.
module pipelined_csel_adder
  import csel_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_sum,
  output logic             output_Cout,
  output logic             output_ovf
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);

  if (SEG < 1 || NSEG < 2 || NSEG * SEG != WIDTH) begin : g_param_check
    $error("pipelined_csel_adder: WIDTH must be a multiple of SEG with at least two segments");
  end

  op_e                op;
  logic [WIDTH-1:0]   bx;
  logic               cin_eff;
  logic [SEG-1:0]     seg0_sum;
  logic               seg0_cout;
  logic [WIDTH-1:SEG] pre_s0, pre_s1;
  logic [NSEG-1:1]    pre_c0, pre_c1;

  always_comb begin
    op      = op_e'(op_sub);
    bx      = (op == OP_SUB) ? ~B : B;
    cin_eff = (op == OP_SUB) ? 1'b1 : Cin;
    {seg0_cout, seg0_sum} = {1'b0, A[SEG-1:0]} + {1'b0, bx[SEG-1:0]} + {{SEG{1'b0}}, cin_eff};
  end

  for (genvar k = 1; k < NSEG; k++) begin : g_seg
    csel_segment #(.SEG(SEG)) u_seg (
      .a    (A[k*SEG +: SEG]),
      .b    (bx[k*SEG +: SEG]),
      .sum0 (pre_s0[k*SEG +: SEG]),
      .sum1 (pre_s1[k*SEG +: SEG]),
      .cout0(pre_c0[k]),
      .cout1(pre_c1[k])
    );
  end

  // Per-stage state: s0 holds resolved segments below the stage index and
  // carry-0 sums above it; s1/c0/c1 keep the unresolved alternatives.
  logic [NSEG-1:0]  valid_q, valid_d, carry_q, carry_d;
  logic [NSEG-2:0]  amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic [WIDTH-1:0] s0_q [NSEG];
  logic [WIDTH-1:0] s0_d [NSEG];
  logic [WIDTH-1:0] s1_q [NSEG];
  logic [WIDTH-1:0] s1_d [NSEG];
  logic [NSEG-1:1]  c0_q [NSEG];
  logic [NSEG-1:1]  c0_d [NSEG];
  logic [NSEG-1:1]  c1_q [NSEG];
  logic [NSEG-1:1]  c1_d [NSEG];
  logic             ovf_q, ovf_d;
  logic             adv;

  always_comb begin
    adv     = out_ready || !valid_q[NSEG-1];
    valid_d = valid_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    ovf_d   = ovf_q;
    if (adv) begin
      valid_d[0] = in_valid;
      carry_d[0] = seg0_cout;
      amsb_d[0]  = A[WIDTH-1];
      bmsb_d[0]  = bx[WIDTH-1];
      s0_d[0]    = {pre_s0, seg0_sum};
      s1_d[0]    = {pre_s1, seg0_sum};
      c0_d[0]    = pre_c0;
      c1_d[0]    = pre_c1;
      for (int unsigned s = 1; s < NSEG; s++) begin
        valid_d[s] = valid_q[s-1];
        s0_d[s]    = s0_q[s-1];
        s1_d[s]    = s1_q[s-1];
        c0_d[s]    = c0_q[s-1];
        c1_d[s]    = c1_q[s-1];
        if (carry_q[s-1]) s0_d[s][s*SEG +: SEG] = s1_q[s-1][s*SEG +: SEG];
        carry_d[s] = carry_q[s-1] ? c1_q[s-1][s] : c0_q[s-1][s];
        if (s < NSEG - 1) begin
          amsb_d[s] = amsb_q[s-1];
          bmsb_d[s] = bmsb_q[s-1];
        end
      end
      // Overflow is registered alongside the final sum so every output is a flop.
      ovf_d = (amsb_q[NSEG-2] == bmsb_q[NSEG-2]) &&
              (s0_d[NSEG-1][WIDTH-1] != amsb_q[NSEG-2]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      carry_q <= '0;
      amsb_q  <= '0;
      bmsb_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned s = 0; s < NSEG; s++) begin
        s0_q[s] <= '0;
        s1_q[s] <= '0;
        c0_q[s] <= '0;
        c1_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
    end
  end

  always_comb begin
    in_ready    = adv;
    out_valid   = valid_q[NSEG-1];
    output_sum  = s0_q[NSEG-1];
    output_Cout = carry_q[NSEG-1];
    output_ovf  = ovf_q;
  end

endmodule
